// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding
// and default bus widths.
package apb_pkg;

   localparam int APB_ADDR_WIDTH = 8;
   localparam int APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB master ACCESS phase.
// Ports: clk, rst_n (sync, active-low), clr (restart),
//        inc (one wait cycle), expired (this wait is the LIMIT-th).
module apb_timeout_cnt #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Fires during the wait cycle that brings the count to LIMIT,
   // so the abort lands on the following edge.
   assign expired = inc && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB master: turns a valid/ready request into one APB transfer
// on slave 1 and returns a single-cycle response pulse.
// Ports: _PCLK, _PRESETn (sync, active-low); req_valid/req_ready,
//        req_write, req_addr, req_wdata; rsp_valid, rsp_rdata,
//        rsp_err; APB _PSEL1, _PENABLE, _PWRITE, _PADDR, _PWDATA,
//        _PRDATA, _PREADY, _PSLVERR.
// Option: APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after
//         TIMEOUT_CYCLES wait states with rsp_err=1.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  _PCLK,
   input  logic                  _PRESETn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  _PSEL1,
   output logic                  _PENABLE,
   output logic                  _PWRITE,
   output logic [ADDR_WIDTH-1:0] _PADDR,
   output logic [DATA_WIDTH-1:0] _PWDATA,
   input  logic [DATA_WIDTH-1:0] _PRDATA,
   input  logic                  _PREADY,
   input  logic                  _PSLVERR
);

   if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   apb_state_e state;
   logic       accept;
   logic       timeout;

   // Gated by reset so no request is taken while reset is held.
   assign req_ready = (state == IDLE) && _PRESETn;
   assign accept    = req_valid && req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   apb_timeout_cnt #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (_PCLK),
      .rst_n  (_PRESETn),
      .clr    (accept),
      .inc    ((state == ACCESS) && !_PREADY),
      .expired(timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge _PCLK) begin
      if (!_PRESETn) begin
         state     <= IDLE;
         _PSEL1    <= 1'b0;
         _PENABLE  <= 1'b0;
         _PWRITE   <= 1'b0;
         _PADDR    <= '0;
         _PWDATA   <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state    <= SETUP;
                  _PSEL1   <= 1'b1;
                  _PENABLE <= 1'b0;
                  _PWRITE  <= req_write;
                  _PADDR   <= req_addr;
                  _PWDATA  <= req_wdata;
               end
            end
            SETUP: begin
               state    <= ACCESS;
               _PENABLE <= 1'b1;
            end
            ACCESS: begin
               if (_PREADY) begin
                  state     <= IDLE;
                  _PSEL1    <= 1'b0;
                  _PENABLE  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= _PSLVERR;
                  rsp_rdata <= _PWRITE ? '0 : _PRDATA;
               end else if (timeout) begin
                  state     <= IDLE;
                  _PSEL1    <= 1'b0;
                  _PENABLE  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               _PSEL1   <= 1'b0;
               _PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule
